// File: rtl/inst_queue.sv
// Instruction queue between fetch and dual-issue decode: compacts partially valid
// fetch groups into a circular buffer and supports flush with delay-slot retention.
module inst_queue #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int INST_W  = 32,
    parameter int PC_W    = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(ISSUE_W + 1),
    localparam int LW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_W-1:0]           in_pc,
    input  logic [FETCH_W-1:0]        in_mask,
    input  logic [FETCH_W*INST_W-1:0] in_inst,
    output logic [ISSUE_W-1:0]        out_valid,
    output logic [ISSUE_W*PC_W-1:0]   out_pc,
    output logic [ISSUE_W*INST_W-1:0] out_inst,
    input  logic [PW-1:0]             pop_cnt,
    input  logic                      flush,
    input  logic                      flush_keep_ds,
    output logic [CW-1:0]             count
);

    logic [PC_W-1:0]   r_pcMem   [DEPTH];
    logic [INST_W-1:0] r_instMem [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [AW-1:0]     w_headNext;
    logic [CW-1:0]     w_remain;
    logic [CW-1:0]     w_pushCnt;
    logic [CW-1:0]     w_pushAdd;
    logic              w_pushOk;
    logic              w_dsTake;
    logic [LW-1:0]     w_dsLane;
    logic [AW-1:0]     w_laneOff [FETCH_W];
    logic [FETCH_W-1:0] w_wrEn;
    logic [AW-1:0]     w_wrAddr  [FETCH_W];

    assign in_ready   = (r_count <= CW'(DEPTH - FETCH_W));
    assign count      = r_count;
    assign w_headNext = r_head + AW'(pop_cnt);
    assign w_remain   = r_count - CW'(pop_cnt);
    assign w_pushOk   = in_valid & in_ready & ~flush;
    assign w_pushAdd  = w_pushOk ? w_pushCnt : '0;
    assign w_dsTake   = flush & flush_keep_ds & (w_remain == '0) & in_valid & in_ready & (|in_mask);

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        w_pushCnt = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            w_laneOff[i] = AW'(w_pushCnt);
            w_pushCnt    = w_pushCnt + CW'(in_mask[i]);
        end
    end

    always_comb begin
        w_dsLane = '0;
        for (int i = FETCH_W - 1; i >= 0; i--) begin
            if (in_mask[i]) begin
                w_dsLane = LW'(i);
            end
        end
    end

    // A delay-slot refill writes the oldest incoming lane at the post-pop head.
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            w_wrEn[i]   = 1'b0;
            w_wrAddr[i] = r_tail + w_laneOff[i];
            if (w_pushOk) begin
                w_wrEn[i] = in_mask[i];
            end else if (w_dsTake && (w_dsLane == LW'(i))) begin
                w_wrEn[i]   = 1'b1;
                w_wrAddr[i] = w_headNext;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (w_wrEn[i]) begin
                r_pcMem[w_wrAddr[i]]   <= in_pc + PC_W'(4 * i);
                r_instMem[w_wrAddr[i]] <= in_inst[i*INST_W +: INST_W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head <= w_headNext;
            if (flush_keep_ds && ((w_remain != '0) || w_dsTake)) begin
                r_tail  <= w_headNext + AW'(1);
                r_count <= CW'(1);
            end else begin
                r_tail  <= w_headNext;
                r_count <= '0;
            end
        end else begin
            r_head  <= w_headNext;
            r_tail  <= r_tail + AW'(w_pushAdd);
            r_count <= r_count + w_pushAdd - CW'(pop_cnt);
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            out_valid[i]                = (r_count > CW'(i));
            out_pc[i*PC_W +: PC_W]      = '0;
            out_inst[i*INST_W +: INST_W] = '0;
            if (out_valid[i]) begin
                out_pc[i*PC_W +: PC_W]       = r_pcMem[r_head + AW'(i)];
                out_inst[i*INST_W +: INST_W] = r_instMem[r_head + AW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a scoreboard queue models the FIFO contents
// and every cycle the presented issue window, occupancy and in_ready are compared.
module tb_inst_queue;

    localparam int DEPTH   = 16;
    localparam int FETCH_W = 2;
    localparam int ISSUE_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [1:0]  in_mask = '0;
    logic [63:0] in_inst = '0;
    logic [1:0]  out_valid;
    logic [63:0] out_pc;
    logic [63:0] out_inst;
    logic [1:0]  pop_cnt = '0;
    logic        flush = 1'b0;
    logic        flush_keep_ds = 1'b0;
    logic [4:0]  count;

    entry_t sb[$];
    int     checks = 0;
    int     passes = 0;
    logic [31:0] pcGen = 32'h0000_1000;

    inst_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .INST_W(32), .PC_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_mask(in_mask), .in_inst(in_inst),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .pop_cnt(pop_cnt), .flush(flush), .flush_keep_ds(flush_keep_ds), .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkOutput();
        logic [1:0] expValid;
        expValid = '0;
        checkVal("count", 64'(count), 64'(sb.size()));
        checkVal("in_ready", 64'(in_ready), 64'((DEPTH - sb.size()) >= FETCH_W));
        for (int i = 0; i < ISSUE_W; i++) begin
            expValid[i] = (i < sb.size());
            checkVal($sformatf("out_pc%0d", i), 64'(out_pc[i*32 +: 32]), expValid[i] ? 64'(sb[i].pc) : 64'd0);
            checkVal($sformatf("out_inst%0d", i), 64'(out_inst[i*32 +: 32]), expValid[i] ? 64'(sb[i].inst) : 64'd0);
        end
        checkVal("out_valid", 64'(out_valid), 64'(expValid));
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [1:0] mask,
                                 input logic [63:0] inst, input int pop, input logic fl, input logic keep);
        bit     ready;
        bit     found;
        entry_t e;
        @(negedge clk);
        in_valid      = v;
        in_pc         = pc;
        in_mask       = mask;
        in_inst       = inst;
        pop_cnt       = 2'(pop);
        flush         = fl;
        flush_keep_ds = keep;
        checkVal("pop_legal", 64'($countones(out_valid) >= pop), 64'd1);
        ready = (DEPTH - sb.size()) >= FETCH_W;
        for (int k = 0; k < pop && sb.size() > 0; k++) void'(sb.pop_front());
        if (fl) begin
            found = 1'b0;
            if (keep && sb.size() > 0) begin
                e = sb[0];
                found = 1'b1;
            end else if (keep && v && ready) begin
                for (int j = 0; j < FETCH_W; j++) begin
                    if (mask[j] && !found) begin
                        e.pc   = pc + 32'(4 * j);
                        e.inst = inst[j*32 +: 32];
                        found  = 1'b1;
                    end
                end
            end
            sb.delete();
            if (found) sb.push_back(e);
        end else if (v && ready) begin
            for (int j = 0; j < FETCH_W; j++) begin
                if (mask[j]) begin
                    e.pc   = pc + 32'(4 * j);
                    e.inst = inst[j*32 +: 32];
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic pushPair(input int pop);
        applyStimulus(1'b1, pcGen, 2'b11, {$urandom, $urandom}, pop, 1'b0, 1'b0);
        pcGen = pcGen + 32'd8;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() > 0; n++)
            applyStimulus(1'b0, '0, 2'b00, '0, (sb.size() >= 2) ? 2 : sb.size(), 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        checkOutput();
        @(negedge clk);
        resetn = 1'b1;

        applyStimulus(1'b1, 32'hBFC0_0000, 2'b11, {32'h2402_0001, 32'h2401_0001}, 0, 1'b0, 1'b0);
        drain();
        applyStimulus(1'b1, 32'h0000_0100, 2'b10, {32'hAAAA_0001, 32'hBBBB_0002}, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0108, 2'b00, {32'hDEAD_0000, 32'hDEAD_0001}, 0, 1'b0, 1'b0);
        drain();

        for (int n = 0; n < DEPTH / FETCH_W; n++) pushPair(0);
        pushPair(0);
        for (int n = 0; n < 20; n++) pushPair(2);
        drain();

        pushPair(0);
        pushPair(0);
        applyStimulus(1'b1, 32'h0000_0400, 2'b01, {32'h0, 32'h1234_5678}, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0500, 2'b11, {$urandom, $urandom}, 1, 1'b1, 1'b1);
        drain();
        pushPair(0);
        pushPair(0);
        applyStimulus(1'b1, 32'h0000_0410, 2'b01, {32'h0, 32'h8765_4321}, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 2'b00, '0, 1, 1'b1, 1'b0);

        applyStimulus(1'b1, 32'h0000_0200, 2'b11, {32'h2222_0004, 32'h2222_0000}, 0, 1'b1, 1'b1);
        drain();
        applyStimulus(1'b1, 32'h0000_0200, 2'b10, {32'h3333_0004, 32'h3333_0000}, 0, 1'b1, 1'b1);
        drain();
        applyStimulus(1'b1, 32'h0000_0200, 2'b11, {32'h4444_0004, 32'h4444_0000}, 0, 1'b1, 1'b0);

        pushPair(0);
        pushPair(1);
        pushPair(1);
        pushPair(0);
        pushPair(1);
        pushPair(0);
        checkVal("count_pre_reset", 64'(count), 64'd9);
        @(negedge clk);
        in_valid = 1'b0;
        in_mask  = '0;
        pop_cnt  = '0;
        flush    = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        sb.delete();
        checkOutput();
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b1, 32'h0000_0300, 2'b11, {32'h5555_0004, 32'h5555_0000}, 0, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
